// File: rtl/adder_seq_pkg.sv
// Shared definitions for the wide-add sequencer: FSM states, byte width and counter sizing.
package adder_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int words);
        int w;
        w = $clog2(words);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adder_seq_ctrl_byte_shift_reg.sv
// W-bit register that parallel-loads and shifts right by one byte, inserting a new byte at the MSB end.
module byte_shift_reg
    import adder_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic                      shift_i,
    input  logic [WORDS*BYTE_W-1:0]   load_data_i,
    input  logic [BYTE_W-1:0]         shift_in_i,
    output logic [WORDS*BYTE_W-1:0]   q_o
);

    localparam int W = WORDS * BYTE_W;

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] shifted;

    generate
        if (WORDS == 1) begin : g_single
            assign shifted = shift_in_i;
        end else begin : g_multi
            assign shifted = {shift_in_i, q_q[W-1:BYTE_W]};
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_data_i;
        end else if (shift_i) begin
            q_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/adder_seq_ctrl.sv
// Drives an external 8-bit adder one byte per cycle to build a WORDS*8-bit add, carry chained LSB first.
// Optional subtract mode (in_sub port, B inverted, carry-in forced 1) when ADD_SEQ_SUB_EN is defined.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORDS*BYTE_W-1:0]   in_a,
    input  logic [WORDS*BYTE_W-1:0]   in_b,
    input  logic                      in_cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                      in_sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORDS*BYTE_W-1:0]   out_sum,
    output logic                      out_cout,
    output logic [BYTE_W-1:0]         add_a,
    output logic [BYTE_W-1:0]         add_b,
    output logic                      add_cin,
    input  logic [BYTE_W-1:0]         add_s,
    input  logic                      add_cout
);

    localparam int W  = WORDS * BYTE_W;
    localparam int CW = cnt_width(WORDS);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          carry_q;
    logic          cout_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          carry_init;
    logic          accept;
    logic          running;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_q;
    logic [BYTE_W-1:0] b_byte;
    logic          unused_hi_bytes;

    assign accept  = (state_q == IDLE) && in_valid;
    assign running = (state_q == RUN);
    assign cnt_d   = cnt_q + CW'(1);

`ifdef ADD_SEQ_SUB_EN
    logic sub_q;

    assign carry_init = in_sub ? 1'b1 : in_cin;
    assign b_byte     = sub_q ? ~b_q[BYTE_W-1:0] : b_q[BYTE_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= in_sub;
        end
    end
`else
    assign carry_init = in_cin;
    assign b_byte     = b_q[BYTE_W-1:0];
`endif

    // Operands shift down a byte per RUN cycle so the active byte is always at the bottom.
    byte_shift_reg #(.WORDS(WORDS)) u_opa (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .shift_i     (running),
        .load_data_i (in_a),
        .shift_in_i  ('0),
        .q_o         (a_q)
    );

    byte_shift_reg #(.WORDS(WORDS)) u_opb (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .shift_i     (running),
        .load_data_i (in_b),
        .shift_in_i  ('0),
        .q_o         (b_q)
    );

    // Sum bytes enter at the MSB; after WORDS shifts byte 0 has reached the LSB.
    byte_shift_reg #(.WORDS(WORDS)) u_res (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (1'b0),
        .shift_i     (running),
        .load_data_i ('0),
        .shift_in_i  (add_s),
        .q_o         (res_q)
    );

    assign unused_hi_bytes = ^{a_q, b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= RUN;
                        cnt_q      <= '0;
                        carry_q    <= carry_init;
                        in_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    carry_q <= add_cout;
                    cnt_q   <= cnt_d;
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= DONE;
                        cnt_q       <= '0;
                        cout_q      <= add_cout;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = res_q;
    assign out_cout  = cout_q;
    assign add_a     = running ? a_q[BYTE_W-1:0] : '0;
    assign add_b     = running ? b_byte : '0;
    assign add_cin   = running ? carry_q : 1'b0;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl (WORDS=4) with a behavioural byte adder attached.
module tb_adder_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = WORDS * 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef ADD_SEQ_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_s;
    logic         add_cout;

    adder_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADD_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    // External byte adder that the sequencer drives.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           acc;
    } exp_t;

    exp_t sb_q[$];
    int   hs_q[$];
    exp_t e;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rst_n && out_valid && !prev_valid) begin
            chk("sb_has_entry_on_valid", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) chk("latency", cyc - sb_q[0].acc, WORDS);
        end
        if (rst_n && out_valid && out_ready) begin
            hs_q.push_back(cyc);
            chk("sb_has_entry_on_handshake", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("out_sum", out_sum, e.sum);
                chk("out_cout", out_cout, e.cout);
            end
        end
        prev_valid <= rst_n && out_valid;
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec);
        int n;
        exp_t x;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        x.sum  = es;
        x.cout = ec;
        x.acc  = cyc;
        sb_q.push_back(x);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
`ifdef ADD_SEQ_SUB_EN
        in_sub    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);
        rst_n = 1'b1;

        // Carry ripples from byte 0 into byte 1.
        send(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
        chk("run_in_ready", in_ready, 0);
        drain();

        // Full carry propagation, carry-in to every upper byte.
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
        chk("b0_add_a", add_a, 8'hFF);
        chk("b0_add_b", add_b, 8'h01);
        chk("b0_add_cin", add_cin, 0);
        for (int i = 1; i < WORDS; i++) begin
            @(negedge clk);
            chk("bN_add_cin", add_cin, 1);
        end
        drain();
        chk("idle_add_a", add_a, 0);
        chk("idle_add_cin", add_cin, 0);

        // Result held under back-pressure.
        out_ready = 1'b0;
        send(32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, 32'h2345678A);
            chk("hold_cout", out_cout, 0);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // Asynchronous reset in the middle of RUN drops the result.
        send(32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_sum", out_sum, 0);
        chk("abort_add_a", add_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
        drain();

        // Back-to-back requests: one result every WORDS+2 cycles.
        hs_q.delete();
        send(32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0);
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0);
        send(32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 32'h00000000, 1'b1);
        drain();
        chk("b2b_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            chk("b2b_period_1", hs_q[1] - hs_q[0], WORDS + 2);
            chk("b2b_period_2", hs_q[2] - hs_q[1], WORDS + 2);
        end

`ifdef ADD_SEQ_SUB_EN
        in_sub = 1'b1;
        send(32'd5, 32'd7, 1'b0, 32'hFFFFFFFE, 1'b0);
        drain();
        send(32'd7, 32'd5, 1'b0, 32'h00000002, 1'b1);
        drain();
        in_sub = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
